// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver with 16x oversampling and 3-sample majority vote per bit.
// Emits rx_done or frame_err as a one-cycle pulse after the stop-bit decision.
module uart_byte_rx #(
    parameter int unsigned CLK_FRE = 50_000_000,
    parameter int unsigned BAUD    = 9600
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned OVS_CNT = CLK_FRE / (BAUD * 16) - 1;
    localparam int unsigned OvsW    = (OVS_CNT > 0) ? $clog2(OVS_CNT + 1) : 1;
    localparam logic [OvsW-1:0] OvsMax = OvsW'(OVS_CNT);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    logic [OvsW-1:0] ovs_cnt_q, ovs_cnt_d;
    logic [3:0]      tick_cnt_q, tick_cnt_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [1:0]      smp_q, smp_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_done_q, rx_done_d;
    logic            frame_err_q, frame_err_d;

    logic tick, decide, maj, fall;

    assign fall   = rx_prev_q & ~rx_sync_q;
    assign tick   = (state_q != StIdle) && (ovs_cnt_q == OvsMax);
    assign decide = tick && (tick_cnt_q == 4'd9);
    // Third sample is taken live at the tick_cnt==9 tick.
    assign maj    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_sync_q) | (smp_q[1] & rx_sync_q);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= StIdle;
            ovs_cnt_q   <= '0;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            smp_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= uart_rx;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            state_q     <= state_d;
            ovs_cnt_q   <= ovs_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            smp_q       <= smp_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ovs_cnt_d   = tick ? '0 : ovs_cnt_q + 1'b1;
        tick_cnt_d  = tick ? tick_cnt_q + 4'd1 : tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        smp_d       = smp_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;

        if (tick && tick_cnt_q == 4'd7) smp_d[0] = rx_sync_q;
        if (tick && tick_cnt_q == 4'd8) smp_d[1] = rx_sync_q;

        unique case (state_q)
            StIdle: begin
                ovs_cnt_d  = '0;
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
                if (fall) state_d = StStart;
            end
            StStart: begin
                if (decide) begin
                    state_d   = maj ? StIdle : StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                // bit_cnt counts data decisions; the start bit's wrap lands here with bit_cnt==0.
                if (decide) begin
                    shift_d   = {maj, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
                if (tick && tick_cnt_q == 4'd15 && bit_cnt_q == 4'd8) state_d = StStop;
            end
            StStop: begin
                if (decide) begin
                    state_d = StIdle;
                    if (maj) begin
                        rx_data_d = shift_q;
                        rx_done_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign rx_data   = rx_data_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = (state_q != StIdle);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Scoreboard bench for uart_byte_rx: bit-banged frames push expected results,
// a negedge monitor pops and compares on every rx_done/frame_err pulse.
module tb_uart_byte_rx;

    localparam int unsigned ClkFre = 1_600_000;
    localparam int unsigned Baud   = 10_000;
    localparam int          BitClk = 160;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       uart_rx   = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    uart_byte_rx #(
        .CLK_FRE(ClkFre),
        .BAUD   (Baud)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .uart_rx  (uart_rx),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_checks   = 0;
    int         n_errors   = 0;
    int         cyc        = 0;
    int         start_cyc  = 0;
    bit         lat_arm    = 1'b0;
    bit         prev_pulse = 1'b0;
    logic [7:0] last_good  = 8'h00;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (sys_rst_n && (rx_done || frame_err)) begin
            check_eq("done_err_excl", {31'b0, rx_done & frame_err}, 32'd0);
            check_eq("pulse_width", {31'b0, prev_pulse}, 32'd0);
            check_eq("busy_at_pulse", {31'b0, rx_busy}, 32'd0);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("pulse_kind", {31'b0, frame_err}, {31'b0, mon_e.is_err});
                check_eq("rx_data", {24'b0, rx_data}, {24'b0, mon_e.data});
                if (lat_arm) begin
                    lat_arm = 1'b0;
                    check_eq("latency", cyc - start_cyc, 32'd1543);
                end
            end
        end
        prev_pulse = sys_rst_n && (rx_done || frame_err);
    end

    task automatic expect_byte(input logic [7:0] d);
        exp_q.push_back('{is_err: 1'b0, data: d});
        last_good = d;
    endtask

    task automatic expect_err();
        exp_q.push_back('{is_err: 1'b1, data: last_good});
    endtask

    task automatic drive_bit(input logic b, input int period);
        uart_rx = b;
        repeat (period) @(negedge sys_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int period);
        start_cyc = cyc;
        drive_bit(1'b0, period);
        for (int i = 0; i < 8; i++) drive_bit(d[i], period);
        drive_bit(stop, period);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge sys_clk);
        check_eq({"drain_", tag}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] partial;
        repeat (3) @(negedge sys_clk);
        check_eq("rst_rx_data", {24'b0, rx_data}, 32'd0);
        check_eq("rst_rx_done", {31'b0, rx_done}, 32'd0);
        check_eq("rst_frame_err", {31'b0, frame_err}, 32'd0);
        check_eq("rst_rx_busy", {31'b0, rx_busy}, 32'd0);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);

        // Loopback-style single byte, with latency check
        expect_byte(8'hA5);
        lat_arm = 1'b1;
        send_frame(8'hA5, 1'b1, BitClk);
        drive_bit(1'b1, BitClk);
        wait_drain("a5", 400);
        check_eq("busy_after_a5", {31'b0, rx_busy}, 32'd0);

        // Back-to-back frames, no idle gap
        expect_byte(8'h00);
        expect_byte(8'hFF);
        send_frame(8'h00, 1'b1, BitClk);
        send_frame(8'hFF, 1'b1, BitClk);
        drive_bit(1'b1, BitClk);
        wait_drain("b2b", 400);

        // Short low glitch: start bit rejected
        uart_rx = 1'b0;
        repeat (5) @(negedge sys_clk);
        check_eq("glitch_busy_rise", {31'b0, rx_busy}, 32'd1);
        repeat (25) @(negedge sys_clk);
        uart_rx = 1'b1;
        for (int i = 0; i < 300 && rx_busy; i++) @(negedge sys_clk);
        check_eq("glitch_busy_fall", {31'b0, rx_busy}, 32'd0);
        repeat (200) @(negedge sys_clk);
        check_eq("glitch_rx_data", {24'b0, rx_data}, 32'h0000_00FF);

        // Framing error then a good frame
        expect_err();
        send_frame(8'h3C, 1'b0, BitClk);
        drive_bit(1'b1, BitClk);
        wait_drain("ferr", 400);
        check_eq("ferr_rx_data", {24'b0, rx_data}, 32'h0000_00FF);
        expect_byte(8'h81);
        send_frame(8'h81, 1'b1, BitClk);
        drive_bit(1'b1, BitClk);
        wait_drain("81", 400);

        // Reset in the middle of data bit 4 of 8'h5A
        partial = 8'h5A;
        drive_bit(1'b0, BitClk);
        for (int i = 0; i < 4; i++) drive_bit(partial[i], BitClk);
        drive_bit(partial[4], BitClk / 2);
        sys_rst_n = 1'b0;
        #1;
        check_eq("mid_rst_rx_data", {24'b0, rx_data}, 32'd0);
        check_eq("mid_rst_rx_busy", {31'b0, rx_busy}, 32'd0);
        check_eq("mid_rst_pulses", {31'b0, rx_done | frame_err}, 32'd0);
        repeat (10) @(negedge sys_clk);
        uart_rx   = 1'b1;
        sys_rst_n = 1'b1;
        last_good = 8'h00;
        repeat (12 * BitClk) @(negedge sys_clk);
        check_eq("post_rst_busy", {31'b0, rx_busy}, 32'd0);
        check_eq("post_rst_rx_data", {24'b0, rx_data}, 32'd0);
        expect_byte(8'hC3);
        send_frame(8'hC3, 1'b1, BitClk);
        drive_bit(1'b1, BitClk);
        wait_drain("c3", 400);

        // Baud tolerance at roughly -2% and +2%
        expect_byte(8'h96);
        send_frame(8'h96, 1'b1, 157);
        drive_bit(1'b1, BitClk);
        wait_drain("tol_fast", 400);
        expect_byte(8'h96);
        send_frame(8'h96, 1'b1, 163);
        drive_bit(1'b1, BitClk);
        wait_drain("tol_slow", 400);
        check_eq("final_busy", {31'b0, rx_busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
